spi_slave: RTL and testbench



---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 37 +++
 rtl/spi_slave.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both ends of the SPI link.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    RELOAD = 2'd3
  } spi_slave_state_t;

  // Flops between an asynchronous pin and its first use.
  localparam int SPI_SYNC_STAGES = 2;

  // {CPOL, CPHA}. The link runs in mode 0: sample on sck rise, change on sck fall.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_pin_sync.sv
// N-bit multi-flop synchronizer with a trailing flop for edge detection.
// Per bit: synchronized level, one-clk rise pulse and one-clk fall pulse.
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int             N       = 1,
  parameter int             STAGES  = SPI_SYNC_STAGES,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);

  logic [N-1:0] stage_q [STAGES];
  logic [N-1:0] last_q;

  // Synchronizer chain plus one extra flop holding the previous level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
      last_q <= RST_VAL;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      last_q <= stage_q[STAGES-1];
    end
  end

  assign level_o = stage_q[STAGES-1];
  assign rise_o  = stage_q[STAGES-1] & ~last_q;
  assign fall_o  = ~stage_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, WIDTH-bit words, fully on clk.
// Optional macro SPI_SLAVE_UNDERRUN_EN adds tx_underrun / underrun_count.
//
// state  | meaning
// IDLE   | chip select high, waiting for cs fall
// LOAD   | one clk: move holding word (or IDLE_WORD) into the tx shifter
// SHIFT  | shifting bits on sck edges
// RELOAD | word done, next sck fall reloads the tx shifter for the next word
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             busy,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic             tx_underrun,
  output logic [7:0]       underrun_count,
`endif
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Pin order in the synchronizer: {sck, cs_n, mosi}. cs_n resets to its
  // inactive level so reset does not look like a select.
  logic [2:0] pin_lvl, pin_rise, pin_fall;

  spi_pin_sync #(
    .N       (3),
    .STAGES  (SPI_SYNC_STAGES),
    .RST_VAL (3'b010)
  ) u_pin_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i ({spi_sck, spi_cs_n, spi_mosi}),
    .level_o (pin_lvl),
    .rise_o  (pin_rise),
    .fall_o  (pin_fall)
  );

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_lvl;
  logic sck_lead, sck_trail;
  logic sync_unused;

  assign sck_rise    = pin_rise[2];
  assign sck_fall    = pin_fall[2];
  assign cs_rise     = pin_rise[1];
  assign cs_fall     = pin_fall[1];
  assign mosi_lvl    = pin_lvl[0];
  assign sync_unused = ^{pin_lvl[2], pin_rise[0], pin_fall[0]};

  // Sampling edge and shifting edge follow from the shared mode constant.
  assign sck_lead  = (SPI_MODE0[1] == 1'b0) ? sck_rise : sck_fall;
  assign sck_trail = (SPI_MODE0[1] == 1'b0) ? sck_fall : sck_rise;

  spi_slave_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rx_sr_q, tx_sr_q, rx_data_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             miso_q, done_q, rx_valid_q;
  logic [WIDTH-1:0] rx_word_d, load_word_d;
  logic             load_now;

  assign rx_word_d   = {rx_sr_q[WIDTH-2:0], mosi_lvl};
  assign load_word_d = hold_full_q ? hold_q : IDLE_WORD;
  // A cs rise wins over a pending load, so an aborted slot consumes nothing.
  assign load_now    = !cs_rise &&
                       ((state_q == LOAD) || ((state_q == RELOAD) && sck_trail));

  // Main FSM: shifters, bit counter, received word and its valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= done_q;
      if (cs_rise) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) state_q <= LOAD;
          end
          LOAD: begin
            tx_sr_q <= load_word_d;
            miso_q  <= load_word_d[WIDTH-1];
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
          SHIFT: begin
            if (sck_lead) begin
              rx_sr_q <= rx_word_d;
              if (cnt_q == CNT_LAST) begin
                rx_data_q <= rx_word_d;
                done_q    <= 1'b1;
                cnt_q     <= '0;
                state_q   <= RELOAD;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            if (sck_trail) begin
              tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
              miso_q  <= tx_sr_q[WIDTH-2];
            end
          end
          RELOAD: begin
            if (sck_trail) begin
              tx_sr_q <= load_word_d;
              miso_q  <= load_word_d[WIDTH-1];
              cnt_q   <= '0;
              state_q <= SHIFT;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // One-deep holding register; a load coinciding with consumption refills it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (load_now && hold_full_q) begin
      if (tx_load) hold_q <= tx_data;
      else         hold_full_q <= 1'b0;
    end else if (tx_load && !hold_full_q) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun_q;
  logic [7:0] urun_cnt_q;

  // Flag every word slot that had to fall back to IDLE_WORD; count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      underrun_q <= load_now && !hold_full_q;
      if (load_now && !hold_full_q && (urun_cnt_q != 8'hFF))
        urun_cnt_q <= urun_cnt_q + 8'd1;
    end
  end

  assign tx_underrun    = underrun_q;
  assign underrun_count = urun_cnt_q;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~hold_full_q;
  assign busy        = ~pin_lvl[1];
  assign spi_miso_oe = busy;
  assign spi_miso    = miso_q & busy;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-word transfers plus
// hand-written back-to-back, abort, load-ignored and reset sequences.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       busy;
  logic       spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
  logic [7:0] underrun_count;
  int         n_urun = 0;
`endif

  spi_slave #(.WIDTH(8), .IDLE_WORD(8'h00)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_load        (tx_load),
    .tx_ready       (tx_ready),
    .busy           (busy),
`ifdef SPI_SLAVE_UNDERRUN_EN
    .tx_underrun    (tx_underrun),
    .underrun_count (underrun_count),
`endif
    .spi_sck        (spi_sck),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_miso_oe    (spi_miso_oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] vq[$];
  int         vc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_valid cycle with its data, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) begin
      vq.push_back(rx_data);
      vc.push_back(cyc);
    end
`ifdef SPI_SLAVE_UNDERRUN_EN
    if (tx_underrun === 1'b1) n_urun++;
`endif
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mode-0 master, clk/8: data set while sck low, slave output sampled on rise.
  // With last=1 chip select rises together with the final sck fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      output logic [7:0] mi, output int rise_cyc);
    mi = '0;
    rise_cyc = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      tick(4);
      spi_sck  = 1'b1;
      mi[i]    = spi_miso;
      rise_cyc = cyc;
      tick(4);
      if (i == 8 - nbits && last) spi_cs_n = 1'b1;
      spi_sck = 1'b0;
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  typedef struct {
    bit         preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] mi, mi2;
    int rc, rc2;
    logic [7:0] saved;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[3] = '{1'b0, 8'h99, 8'hC3, 8'hC3, 8'h00};
    vecs[4] = '{1'b1, 8'h01, 8'h80, 8'h80, 8'h01};

    reset_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    tx_load = 1'b0; tx_data = '0;
    tick(3);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_miso_oe", spi_miso_oe, 0);
    reset_n = 1'b1;
    tick(4);

    for (int v = 0; v < 5; v++) begin
      vq.delete(); vc.delete();
      if (vecs[v].preload) begin
        load_word(vecs[v].tx);
        chk($sformatf("v%0d_txready_low", v), tx_ready, 0);
      end
      spi_cs_n = 1'b0;
      tick(6);
      chk($sformatf("v%0d_busy", v), busy, 1);
      chk($sformatf("v%0d_oe", v), spi_miso_oe, 1);
      chk($sformatf("v%0d_txready_after_load", v), tx_ready, 1);
      xfer(vecs[v].mosi, 8, 1'b1, mi, rc);
      tick(6);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_rx_pulses", v), vq.size(), 1);
      if (vq.size() > 0) begin
        chk($sformatf("v%0d_rx_data", v), vq[0], vecs[v].exp_rx);
        chk($sformatf("v%0d_rx_latency", v), vc[0], rc + 4);
      end
      chk($sformatf("v%0d_miso_word", v), mi, vecs[v].exp_miso);
    end

    // Back-to-back: 0x11 preloaded, 0x22 loaded once word 1 has taken 0x11.
    vq.delete(); vc.delete();
    load_word(8'h11);
    spi_cs_n = 1'b0;
    tick(6);
    load_word(8'h22);
    chk("b2b_txready_full", tx_ready, 0);
    xfer(8'hF0, 8, 1'b0, mi, rc);
    xfer(8'h0F, 8, 1'b1, mi2, rc2);
    tick(6);
    chk("b2b_rx_pulses", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_rx0", vq[0], 8'hF0);
      chk("b2b_rx1", vq[1], 8'h0F);
      chk("b2b_lat1", vc[1], rc2 + 4);
    end
    chk("b2b_miso0", mi, 8'h11);
    chk("b2b_miso1", mi2, 8'h22);
    chk("b2b_txready_end", tx_ready, 1);

    // Abort after 5 bits, then a full word.
    vq.delete(); vc.delete();
    saved = rx_data;
    spi_cs_n = 1'b0;
    tick(6);
    xfer(8'hFF, 5, 1'b1, mi, rc);
    tick(8);
    chk("abort_no_pulse", vq.size(), 0);
    chk("abort_rx_hold", rx_data, saved);
    spi_cs_n = 1'b0;
    tick(6);
    xfer(8'h81, 8, 1'b1, mi, rc);
    tick(6);
    chk("abort_next_pulses", vq.size(), 1);
    chk("abort_next_rx", rx_data, 8'h81);

    // A load while the holding register is full is dropped.
    load_word(8'h55);
    load_word(8'h66);
    spi_cs_n = 1'b0;
    tick(6);
    chk("ign_txready", tx_ready, 1);
    xfer(8'h3A, 8, 1'b1, mi, rc);
    tick(6);
    chk("ign_miso", mi, 8'h55);
    chk("ign_txready_end", tx_ready, 1);

    // Reset in the middle of a word, with the holding register refilled.
    vq.delete(); vc.delete();
    spi_cs_n = 1'b0;
    tick(6);
    load_word(8'h77);
    xfer(8'hE7, 3, 1'b0, mi, rc);
    chk("mid_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rx_data", rx_data, 0);
    chk("mid_rx_valid", rx_valid, 0);
    chk("mid_tx_ready", tx_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_miso", spi_miso, 0);
    chk("mid_oe", spi_miso_oe, 0);
    spi_cs_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(8);
    chk("mid_no_pulse", vq.size(), 0);

    // Next transfer after reset, nothing preloaded: IDLE_WORD goes out.
`ifdef SPI_SLAVE_UNDERRUN_EN
    n_urun = 0;
`endif
    spi_cs_n = 1'b0;
    tick(6);
    xfer(8'h5A, 8, 1'b1, mi, rc);
    tick(6);
    chk("post_rx_pulses", vq.size(), 1);
    chk("post_rx_data", rx_data, 8'h5A);
    chk("post_miso_idle", mi, 8'h00);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("urun_pulses", n_urun, 1);
    chk("urun_count", underrun_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
